// File: rtl/fifo_wptr_full_if.sv
// Write-client bundle for the async FIFO write-pointer block.
// The master side drives requests and the read pointer; the slave side returns RAM controls and status.
interface fifo_wptr_full_if #(
    parameter int addr_width = 3
);
    logic                  winc;
    logic                  clr_ovf;
    logic [addr_width:0]   rptr_async;
    logic [addr_width-1:0] waddr;
    logic                  wclken;
    logic [addr_width:0]   wptr;
    logic                  wfull;
    logic                  walmost_full;
    logic [addr_width:0]   wlevel;
    logic                  woverflow;

    modport master (
        output winc, clr_ovf, rptr_async,
        input  waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, clr_ovf, rptr_async,
        output waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost-full, fill-level and overflow logic for the async FIFO.
// The read Gray pointer is brought in through a flop chain and only the last stage is used.
module fifo_wptr_full #(
    parameter int addr_width   = 3,
    parameter int afull_thresh = 6,
    parameter int sync_stages  = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wptr_full_if.slave   bus
);
    // XOR mask turning a read Gray pointer into the write Gray value that means "full"
    localparam logic [addr_width:0] FULL_FLIP    = {2'b11, {(addr_width-1){1'b0}}};
    localparam logic [31:0]         AFULL_THRESH = 32'(afull_thresh);

    logic [addr_width:0] wbin_reg;
    logic [addr_width:0] wptr_reg;
    logic [addr_width:0] wlevel_reg;
    logic                wfull_reg;
    logic                walmost_full_reg;
    logic                woverflow_reg;

    logic [addr_width:0] rq;
    logic [addr_width:0] rbin_s;
    logic [addr_width:0] wbin_next;
    logic [addr_width:0] wgray_next;
    logic [addr_width:0] wlevel_next;
    logic                wr_en;
    logic                wfull_next;
    logic                walmost_full_next;

    genvar gi;
    generate
        for (gi = 0; gi < sync_stages; gi++) begin : g_sync
            logic [addr_width:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge wclk or negedge wrst_n) begin
                    if (!wrst_n) q_reg <= '0;
                    else         q_reg <= bus.rptr_async;
                end
            end else begin : g_rest
                always_ff @(posedge wclk or negedge wrst_n) begin
                    if (!wrst_n) q_reg <= '0;
                    else         q_reg <= g_sync[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign rq = g_sync[sync_stages-1].q_reg;

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= addr_width; i++) begin
            rbin_s[i] = ^(rq >> i);
        end
    end

    assign wr_en             = bus.winc & ~wfull_reg;
    assign wbin_next         = wbin_reg + {{addr_width{1'b0}}, wr_en};
    assign wgray_next        = (wbin_next >> 1) ^ wbin_next;
    assign wlevel_next       = wbin_next - rbin_s;
    assign wfull_next        = (wgray_next == (rq ^ FULL_FLIP));
    assign walmost_full_next = {{(31-addr_width){1'b0}}, wlevel_next} >= AFULL_THRESH;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_reg         <= '0;
            wptr_reg         <= '0;
            wlevel_reg       <= '0;
            wfull_reg        <= 1'b0;
            walmost_full_reg <= 1'b0;
            woverflow_reg    <= 1'b0;
        end else begin
            wbin_reg         <= wbin_next;
            wptr_reg         <= wgray_next;
            wlevel_reg       <= wlevel_next;
            wfull_reg        <= wfull_next;
            walmost_full_reg <= walmost_full_next;
            // a new overflow in the same cycle as a clear takes priority
            woverflow_reg    <= (bus.winc & wfull_reg) | (woverflow_reg & ~bus.clr_ovf);
        end
    end

    assign bus.waddr        = wbin_reg[addr_width-1:0];
    assign bus.wclken       = wr_en;
    assign bus.wptr         = wptr_reg;
    assign bus.wfull        = wfull_reg;
    assign bus.walmost_full = walmost_full_reg;
    assign bus.wlevel       = wlevel_reg;
    assign bus.woverflow    = woverflow_reg;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a count-based occupancy model predicts each cycle,
// and independent monitors compare the DUT outputs against the queued predictions.
module tb_fifo_wptr_full;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;
    localparam int SYNC  = 2;
    localparam int THR   = 6;

    typedef logic [AW:0] ptr_t;

    typedef struct {
        int waddr;
        int wptr;
        int wlevel;
        bit wfull;
        bit walm;
        bit walm2;
        bit wovf;
        bit wen;
    } exp_t;

    logic wclk;
    logic wrst_n;

    fifo_wptr_full_if #(.addr_width(AW)) bus ();
    fifo_wptr_full_if #(.addr_width(AW)) bus2 ();

    assign bus2.winc       = bus.winc;
    assign bus2.clr_ovf    = bus.clr_ovf;
    assign bus2.rptr_async = bus.rptr_async;

    fifo_wptr_full #(.addr_width(AW), .afull_thresh(THR), .sync_stages(SYNC)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .bus(bus)
    );

    fifo_wptr_full #(.addr_width(AW), .afull_thresh(DEPTH), .sync_stages(SYNC)) dut_thr_max (
        .wclk(wclk), .wrst_n(wrst_n), .bus(bus2)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    exp_t reg_q[$];
    bit   en_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: total accepted writes and the read count seen after the synchronizer delay
    int m_wr;
    bit m_full;
    bit m_ovf;
    int rd_count;
    int rhist[$];
    int prev_wptr;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit w, input bit c);
        int   rd_used;
        int   occ;
        bit   en;
        exp_t e;
        @(negedge wclk);
        bus.winc       = w;
        bus.clr_ovf    = c;
        bus.rptr_async = ptr_t'(gray(rd_count % PMOD));
        en = w && !m_full;
        en_q.push_back(en);
        rd_used = rhist.pop_front();
        rhist.push_back(rd_count % PMOD);
        m_wr += int'(en);
        occ = ((m_wr % PMOD) - rd_used + PMOD) % PMOD;
        e.wen    = en;
        e.waddr  = m_wr % DEPTH;
        e.wptr   = gray(m_wr % PMOD);
        e.wlevel = occ;
        e.wfull  = (occ == DEPTH);
        e.walm   = (occ >= THR);
        e.walm2  = (occ >= DEPTH);
        e.wovf   = (w && m_full) || (m_ovf && !c);
        m_full = e.wfull;
        m_ovf  = e.wovf;
        reg_q.push_back(e);
        $display("cyc winc=%0b clr=%0b rd=%0d -> waddr=%0d wptr=%0d lvl=%0d full=%0b ovf=%0b",
                 w, c, rd_count % PMOD, e.waddr, e.wptr, e.wlevel, e.wfull, e.wovf);
    endtask

    task automatic do_reset();
        @(negedge wclk);
        bus.winc       = 1'b0;
        bus.clr_ovf    = 1'b0;
        rd_count       = 0;
        bus.rptr_async = '0;
        #3 wrst_n = 1'b0;
        #1;
        chk("rst_waddr", 32'(bus.waddr), 0);
        chk("rst_wptr", 32'(bus.wptr), 0);
        chk("rst_wfull", 32'(bus.wfull), 0);
        chk("rst_walmost_full", 32'(bus.walmost_full), 0);
        chk("rst_wlevel", 32'(bus.wlevel), 0);
        chk("rst_woverflow", 32'(bus.woverflow), 0);
        chk("rst_wfull_thrmax", 32'(bus2.wfull), 0);
        $display("reset asserted, outputs checked");
        repeat (2) @(posedge wclk);
        #3 wrst_n = 1'b1;
        m_wr = 0; m_full = 0; m_ovf = 0; prev_wptr = 0;
        rhist = {};
        repeat (SYNC) rhist.push_back(0);
    endtask

    // Registered-output monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                chk("waddr", 32'(bus.waddr), e.waddr);
                chk("wptr", 32'(bus.wptr), e.wptr);
                chk("wptr_one_bit", $countones(bus.wptr ^ ptr_t'(prev_wptr)), int'(e.wen));
                chk("wlevel", 32'(bus.wlevel), e.wlevel);
                chk("wfull", 32'(bus.wfull), 32'(e.wfull));
                chk("walmost_full", 32'(bus.walmost_full), 32'(e.walm));
                chk("woverflow", 32'(bus.woverflow), 32'(e.wovf));
                chk("walmost_full_thrmax", 32'(bus2.walmost_full), 32'(e.walm2));
                chk("wfull_thrmax", 32'(bus2.wfull), 32'(e.wfull));
                prev_wptr = e.wptr;
            end
        end
    end

    // Combinational write-enable monitor
    initial begin
        bit en;
        forever begin
            @(negedge wclk);
            #2;
            if (en_q.size() > 0) begin
                en = en_q.pop_front();
                chk("wclken", 32'(bus.wclken), 32'(en));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        wrst_n         = 1'b1;
        bus.winc       = 1'b0;
        bus.clr_ovf    = 1'b0;
        bus.rptr_async = '0;
        rd_count       = 0;
        do_reset();

        // fill from empty: full and level 8 after the eighth write
        repeat (DEPTH) step(1, 0);
        step(0, 0);

        // overflow set, hold, clear, and set-wins-over-clear
        step(1, 0);
        step(0, 0);
        step(0, 1);
        step(1, 1);
        step(0, 0);
        step(0, 1);

        // read pointer advances to 2: full drops after the synchronizer delay, then refill
        rd_count = 2;
        repeat (4) step(0, 0);
        repeat (2) step(1, 0);
        step(0, 0);

        // drain to a gap of 3, then stream four laps with the reader trailing
        guard = 0;
        while (rd_count < m_wr - 3 && guard < 20) begin
            rd_count++;
            guard++;
            step(0, 0);
        end
        repeat (4 * DEPTH) begin
            rd_count++;
            step(1, 0);
        end

        // randomized traffic: write-heavy, balanced, then read-heavy
        for (int ph = 0; ph < 3; ph++) begin
            repeat (120) begin
                bit w;
                bit c;
                w = ($urandom_range(0, 3) >= ph + 1);
                c = ($urandom_range(0, 15) == 0);
                if (rd_count < m_wr && $urandom_range(0, 3) <= ph) rd_count++;
                step(w, c);
            end
        end

        // fill to full, overflow, then reset mid-stream
        guard = 0;
        while (!m_full && guard < 40) begin
            guard++;
            step(1, 0);
        end
        chk("fill_to_full_bounded", 32'(m_full), 1);
        step(1, 0);
        @(posedge wclk);
        do_reset();
        step(1, 0);
        step(0, 0);

        @(posedge wclk);
        #2;
        chk("queues_drained", 32'(reg_q.size() + en_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
